// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: word width, FSM encodings, halt word.
// The CHK encoding exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int WORD_LEN = 32;
    localparam logic [WORD_LEN-1:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction storage for the loader: MEM_WORDS x 32, one synchronous write port and one
// asynchronous read port. Module name imem_ram is what the loader instantiates.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [WORD_LEN-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [WORD_LEN-1:0] rdata
);

    logic [WORD_LEN-1:0] mem [MEM_WORDS];

    // NOTE: the array has no reset; stale words are hidden by the loader's read mask, and a reset
    // port here would turn the RAM into a register file.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian program from a byte stream into imem_ram,
// then releases the core. Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [31:0]         addr_i,
    output logic [WORD_LEN-1:0] inst,
    output logic                core_rst_n,
    output logic                load_err
);

    localparam int AW = $clog2(MEM_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_POST = S_CHK;
`else
    localparam state_t S_POST = S_RUN;
`endif

    state_t              state, state_nxt;
    logic [15:0]         n_words;
    logic [15:0]         word_cnt;
    logic [1:0]          byte_cnt;
    logic [23:0]         partial;
    logic [15:0]         len_full;
    logic                accept;
    logic                last_word;
    logic                we;
    logic [WORD_LEN-1:0] wdata;
    logic [WORD_LEN-1:0] rdata;
    logic [29:0]         index;
    logic                unused_addr_lsbs;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          checksum;
`endif

    assign accept    = rx_valid && rx_ready;
    assign len_full  = {rx_data, n_words[7:0]};
    assign last_word = (word_cnt + 16'd1) == n_words;

    // NOTE: state and datapath registers use non-blocking assignments so every always_ff
    // reads the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        core_rst_n = 1'b0;
        load_err   = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_LEN;
            S_LEN: begin
                rx_ready = 1'b1;
                if (accept && byte_cnt == 2'd1) begin
                    if (len_full == 16'd0)                      state_nxt = S_POST;
                    else if ({16'd0, len_full} > 32'(MEM_WORDS)) state_nxt = S_ERR;
                    else                                         state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (accept && byte_cnt == 2'd3 && last_word) state_nxt = S_POST;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                if (accept) state_nxt = (rx_data == checksum) ? S_RUN : S_ERR;
            end
`endif
            S_RUN: core_rst_n = 1'b1;
            S_ERR: load_err   = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters and the partial word move only on an accepted byte, so stalls hold them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_words  <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            partial  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else if (accept) begin
            case (state)
                S_LEN: begin
                    if (byte_cnt == 2'd0) begin
                        n_words[7:0] <= rx_data;
                        byte_cnt     <= 2'd1;
                    end else begin
                        n_words[15:8] <= rx_data;
                        byte_cnt      <= 2'd0;
                    end
                end
                S_DATA: begin
                    case (byte_cnt)
                        2'd0:    partial[7:0]   <= rx_data;
                        2'd1:    partial[15:8]  <= rx_data;
                        2'd2:    partial[23:16] <= rx_data;
                        default: word_cnt       <= word_cnt + 16'd1;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum <= checksum + rx_data;
`endif
                end
                default: ;
            endcase
        end
    end

    assign we    = (state == S_DATA) && accept && (byte_cnt == 2'd3);
    assign wdata = {rx_data, partial};

    imem_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (word_cnt[AW-1:0]),
        .wdata (wdata),
        .raddr (index[AW-1:0]),
        .rdata (rdata)
    );

    // Byte offset within a word carries no meaning for fetch.
    assign unused_addr_lsbs = ^addr_i[1:0];
    assign index            = addr_i[31:2];
    assign inst = (state == S_RUN && index < {14'd0, n_words}) ? rdata : HALT_WORD;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus randomized loads, compared every
// cycle against a byte-stream level model of the load protocol.
module tb_imem_loader;

    localparam int MW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef logic [7:0] bytes_t[$];

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] addr_i;
    logic [31:0] inst;
    logic        core_rst_n;
    logic        load_err;

    imem_loader #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .addr_i     (addr_i),
        .inst       (inst),
        .core_rst_n (core_rst_n),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: interprets the accepted byte stream ----------------
    bit          m_valid = 0;
    bit          m_idle;
    int          m_acc;
    int          m_len_lo;
    int          m_n;
    logic [7:0]  m_sum;
    logic [7:0]  m_ckbyte;
    logic [7:0]  m_lane [4];
    logic [31:0] m_mem [MW];

    function automatic bit m_receiving();
        if (!m_valid || m_idle) return 0;
        if (m_acc < 2) return 1;
        if (m_n > MW) return 0;
        return m_acc < 2 + 4 * m_n + CK;
    endfunction

    function automatic bit m_err();
        if (!m_valid || m_idle || m_acc < 2) return 0;
        if (m_n > MW) return 1;
        return (CK == 1) && (m_acc == 2 + 4 * m_n + 1) && (m_ckbyte != m_sum);
    endfunction

    function automatic bit m_run();
        if (!m_valid || m_idle || m_acc < 2 || m_n > MW) return 0;
        return (m_acc == 2 + 4 * m_n + CK) && !m_err();
    endfunction

    function automatic logic [31:0] m_inst(input logic [31:0] a);
        logic [31:0] idx;
        idx = a >> 2;
        if (m_run() && idx < 32'(m_n)) return m_mem[idx];
        return 32'h0;
    endfunction

    task automatic m_consume(input logic [7:0] b);
        int d;
        if (m_acc == 0) m_len_lo = int'(b);
        else if (m_acc == 1) m_n = m_len_lo + 256 * int'(b);
        else begin
            d = m_acc - 2;
            if (d < 4 * m_n) begin
                m_lane[d % 4] = b;
                m_sum = m_sum + b;
                if (d % 4 == 3) m_mem[d / 4] = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
            end else begin
                m_ckbyte = b;
            end
        end
        m_acc++;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1;
            m_idle  = 1;
            m_acc   = 0;
            m_n     = 0;
            m_sum   = 8'h00;
        end else if (m_valid) begin
            if (m_idle) m_idle = 0;
            else if (rx_valid && m_receiving()) m_consume(rx_data);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("rx_ready",   32'(rx_ready),   32'(m_receiving()));
            check("core_rst_n", 32'(core_rst_n), 32'(m_run()));
            check("load_err",   32'(load_err),   32'(m_err()));
            check("inst",       inst,            m_inst(addr_i));
        end
    end

    // ---------------- stimulus ----------------
    bit addr_hold = 0;

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (!addr_hold) begin
                if ($urandom_range(0, 7) == 0) addr_i = $urandom;
                else addr_i = 32'($urandom_range(0, 63));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr_hold = 1;
        addr_i    = a;
        #1;
        check(name, inst, exp);
        addr_hold = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        check("byte_accepted", 32'(got), 32'd1);
    endtask

    task automatic send_all(input bytes_t q, input int gap);
        foreach (q[i]) send_byte(q[i], gap);
    endtask

    task automatic junk(input int n);
        repeat (n) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick();
        end
        rx_valid = 1'b0;
    endtask

    bytes_t prog_a = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};

    initial begin
        bytes_t q;
        int     n;
        int     abort_at;
        int     gap;
        logic [7:0] sum;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        addr_i   = 32'h0;
        tick();
        tick();
        tick();
        check("rst_rx_ready",   32'(rx_ready),   32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_load_err",   32'(load_err),   32'd0);
        rst_n = 1'b1;

        // Two-word program, back-to-back bytes.
        send_all(prog_a, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hD6, 0);
`endif
        check("a_run_after_last", 32'(core_rst_n), 32'd1);
        peek("a_inst0", 32'd0, 32'h0010_0013);
        peek("a_inst4", 32'd4, 32'h0020_0093);
        peek("a_inst5", 32'd5, 32'h0020_0093);
        peek("a_inst8", 32'd8, 32'h0000_0000);
        junk(6);
        repeat (8) tick();

        // Same program with rx_valid toggling every cycle.
        do_reset();
        send_all(prog_a, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hD6, 1);
`endif
        check("b_run_after_last", 32'(core_rst_n), 32'd1);
        peek("b_inst4", 32'd4, 32'h0020_0093);
        peek("b_inst8", 32'd8, 32'h0000_0000);
        repeat (8) tick();

        // Oversized length: 257 words.
        do_reset();
        send_all('{8'h01, 8'h01}, 0);
        tick();
        check("d_load_err",   32'(load_err),   32'd1);
        check("d_rx_ready",   32'(rx_ready),   32'd0);
        check("d_core_rst_n", 32'(core_rst_n), 32'd0);
        peek("d_inst4", 32'd4, 32'h0000_0000);
        junk(5);

        // Reset mid-word, then a clean one-word load.
        do_reset();
        send_all('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC}, 0);
        do_reset();
        send_all('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h14, 0);
`endif
        check("e_core_rst_n", 32'(core_rst_n), 32'd1);
        peek("e_inst0", 32'd0, 32'h1234_5678);
        repeat (6) tick();

        // Empty program.
        do_reset();
        send_all('{8'h00, 8'h00}, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check("f_core_rst_n", 32'(core_rst_n), 32'd1);
        peek("f_inst0", 32'd0, 32'h0000_0000);
        peek("f_inst4", 32'd4, 32'h0000_0000);
        repeat (10) tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        send_all('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 0);
        check("g_good_sum_run", 32'(core_rst_n), 32'd1);
        peek("g_inst0", 32'd0, 32'h0403_0201);
        do_reset();
        send_all('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B}, 0);
        check("g_bad_sum_err", 32'(load_err), 32'd1);
        repeat (4) tick();
`endif

        // Randomized loads, with occasional oversize, aborts and bad checksums.
        for (int it = 0; it < 12; it++) begin
            do_reset();
            q.delete();
            n = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 12));
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
            sum = 8'h00;
            if (n <= MW) begin
                for (int k = 0; k < 4 * n; k++) begin
                    q.push_back(8'($urandom));
                    sum = sum + q[q.size() - 1];
                end
                if (CK == 1) q.push_back(($urandom_range(0, 3) == 0) ? (sum ^ 8'h01) : sum);
            end
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, q.size() - 1)) : q.size();
            for (int k = 0; k < abort_at; k++) begin
                gap = int'($urandom_range(0, 2));
                send_byte(q[k], gap);
            end
            junk(int'($urandom_range(0, 4)));
            repeat (20) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 256, meaning instruction-memory depth in 32-bit words (power of two, 4..65536).
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset; reset is synchronous and active-low.
REQ-004 SHALL provide port rx_data  input  8  program byte stream.
REQ-005 SHALL provide port rx_valid  input  1  rx_data valid.
REQ-006 SHALL provide port rx_ready  output  1  loader accepts byte this cycle.
REQ-007 SHALL provide port addr_i  input  32  byte fetch address from core.
REQ-008 SHALL provide port inst  output  32  fetched instruction word to core.
REQ-009 SHALL provide port core_rst_n  output  1  active-low reset to core; released only after a good load.
REQ-010 SHALL provide port load_err  output  1  sticky load-failure flag.

Function
REQ-011 SHALL accept a byte only on a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL be a pure function of state.
REQ-012 SHALL implement states IDLE, LEN, DATA, CHK, RUN, ERR; IDLE->LEN unconditionally on the first cycle after reset.
REQ-013 LEN: rx_ready=1; accepts 2 bytes, little-endian 16-bit word count N; after byte 2: N=0 -> CHK (macro on) or RUN (off); N>MEM_WORDS -> ERR; else -> DATA.
REQ-014 DATA: rx_ready=1; bytes assembled little-endian (first byte = bits 7:0); on 4th byte, word written to mem[word_cnt], word_cnt increments.
REQ-015 DATA: after byte 4*N accepted, next state CHK (macro on) or RUN (off); RUN visible the cycle after the final accept.
REQ-016 RUN: rx_ready=0, core_rst_n=1; remains in RUN until rst_n asserted; extra bytes ignored.
REQ-017 ERR: rx_ready=0, core_rst_n=0, load_err=1; remains until rst_n asserted.
REQ-018 core_rst_n SHALL be 0 in every state except RUN.
REQ-019 inst SHALL be combinational from addr_i: index addr_i[31:2]; if state==RUN and index<N -> mem[index]; otherwise 32'h00000000 (core halt encoding).
REQ-020 addr_i[1:0] SHALL be ignored; no misalignment error.
REQ-021 Stalled rx_valid (0) in any receive state SHALL hold all counters and partial word unchanged, for any duration.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force state IDLE, rx_ready=0, core_rst_n=0, load_err=0, word_cnt=0, byte_cnt=0, N=0, checksum=0.
REQ-023 Reset mid-load SHALL discard partial progress; subsequent load starts at LEN; memory array SHALL NOT be cleared (REQ-019 masks stale words).

Configuration
REQ-024 Macro IMEM_LOADER_CHECKSUM_EN defined: CHK state present; sum mod 256 of all data bytes (length bytes excluded) compared to one trailing byte; match -> RUN, mismatch -> ERR.
REQ-025 Macro undefined: no CHK state, no checksum register; DATA/LEN go directly to RUN per REQ-013/REQ-015.

Structure
REQ-026 Shared package SHALL hold WORD_LEN (32), loader state encodings, and halt word constant 32'h00000000.
REQ-027 Storage SHALL be sub-module imem_ram: MEM_WORDS x 32, one synchronous write port, one asynchronous read port.

Verification
REQ-028 Load N=2, bytes 13 00 10 00, 93 00 20 00 -> mem[0]=32'h00100013, mem[1]=32'h00200093; core_rst_n=1 cycle after 8th data byte; inst@addr_i=4 = 32'h00200093; inst@addr_i=8 = 0.
REQ-029 Same load with rx_valid toggling 1/0 every cycle -> identical memory contents and result; RUN entered the cycle after last accept.
REQ-030 Length bytes 01 01 (N=257) with MEM_WORDS=256 -> ERR, load_err=1, rx_ready=0, core_rst_n=0, inst=0.
REQ-031 Macro on, N=1, data 01 02 03 04, checksum 0A -> RUN; checksum 0B -> ERR.
REQ-032 rst_n pulsed after 3 data bytes, then full N=1 load of 78 56 34 12 -> mem[0]=32'h12345678, no stale byte mixing.
REQ-033 N=0 -> RUN (macro off) with inst=0 for every addr_i.
